// File: rtl/cb_sched_pkg.sv
// Shared constants for the CB token scheduler: FSM encodings and error bit positions.
package cb_sched_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_SEND   = 3'd2;
    localparam logic [2:0] ST_ACK_LO = 3'd3;
    localparam logic [2:0] ST_ACK_HI = 3'd4;

    localparam int ERR_TMO = 0;
    localparam int ERR_OVF = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cb_sched_sync2.sv
// Two-flop synchronizer for the self-timed CB ack; idles high to match the inactive ack level.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/cb_sched.sv
// Round-robin scheduler sharing one CB branch element between requesters A and B,
// with per-branch credit tracking and ack-timeout detection.
module cb_sched
    import cb_sched_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int SEND_W  = 2,
    parameter int TMO     = 255
) (
    input  logic       CLK,
    input  logic       MR,
    input  logic [1:0] Req_in,
    input  logic [1:0] Dest_in,
    output logic [1:0] Gnt_out,
    output logic       Br,
    output logic       CB_Send_in,
    input  logic       CB_Ack_out,
    input  logic       Drain_a,
    input  logic       Drain_b,
    output logic       Busy,
    output logic [1:0] Err
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int TW = $clog2(max2(TMO, SEND_W) + 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt_a, cnt_b;
    logic [TW-1:0] tmr;
    logic          ptr;
    logic          ack_s;
    logic [1:0]    elig;
    logic          take_v, take, gdest, inc_a, inc_b;

    sync2 u_ack_sync (.clk(CLK), .rst(MR), .d(CB_Ack_out), .q(ack_s));

    always_comb begin
        for (int i = 0; i < 2; i++)
            elig[i] = Req_in[i] && ((Dest_in[i] ? cnt_b : cnt_a) < CW'(CREDITS));
        take_v = 1'b0;
        take   = 1'b0;
        if (state == ST_IDLE) begin
            if (&elig) begin
                take_v = 1'b1;
                take   = ptr;
            end else if (elig[0]) begin
                take_v = 1'b1;
            end else if (elig[1]) begin
                take_v = 1'b1;
                take   = 1'b1;
            end
        end
        gdest = Dest_in[take];
        inc_a = take_v && !gdest;
        inc_b = take_v && gdest;
    end

    assign Busy = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (MR) begin
            state      <= ST_IDLE;
            CB_Send_in <= 1'b1;
            Br         <= 1'b0;
            Gnt_out    <= 2'b00;
            Err        <= 2'b00;
            cnt_a      <= '0;
            cnt_b      <= '0;
            ptr        <= 1'b0;
            tmr        <= '0;
        end else begin
            Gnt_out <= 2'b00;

            // Grant and drain on the same branch cancel; a drain with nothing outstanding is an error.
            if (inc_a && !Drain_a)
                cnt_a <= cnt_a + 1'b1;
            else if (Drain_a && !inc_a) begin
                if (cnt_a == '0) Err[ERR_OVF] <= 1'b1;
                else             cnt_a <= cnt_a - 1'b1;
            end
            if (inc_b && !Drain_b)
                cnt_b <= cnt_b + 1'b1;
            else if (Drain_b && !inc_b) begin
                if (cnt_b == '0) Err[ERR_OVF] <= 1'b1;
                else             cnt_b <= cnt_b - 1'b1;
            end

            case (state)
                ST_IDLE: if (take_v) begin
                    state   <= ST_SETUP;
                    Gnt_out <= take ? 2'b10 : 2'b01;
                    Br      <= gdest;
                    ptr     <= ~take;
                end
                ST_SETUP: begin
                    state      <= ST_SEND;
                    CB_Send_in <= 1'b0;
                    tmr        <= '0;
                end
                ST_SEND: begin
                    if (tmr == TW'(SEND_W - 1)) begin
                        state      <= ST_ACK_LO;
                        CB_Send_in <= 1'b1;
                        tmr        <= '0;
                    end else
                        tmr <= tmr + 1'b1;
                end
                ST_ACK_LO: begin
                    if (!ack_s) begin
                        state <= ST_ACK_HI;
                        tmr   <= '0;
                    end else if (tmr == TW'(TMO - 1)) begin
                        state        <= ST_IDLE;
                        Err[ERR_TMO] <= 1'b1;
                    end else
                        tmr <= tmr + 1'b1;
                end
                ST_ACK_HI: begin
                    if (ack_s)
                        state <= ST_IDLE;
                    else if (tmr == TW'(TMO - 1)) begin
                        state        <= ST_IDLE;
                        Err[ERR_TMO] <= 1'b1;
                    end else
                        tmr <= tmr + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
